// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode/execute signal bundle for the ID/EX pipeline register
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] RD1D, RD2D;
  logic [IMM_W-1:0]  ImmD;
  logic [RA_W-1:0]   RsD, RtD, RdD;
  logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [ALUC_W-1:0] ALUControlD;
  logic              ValidD;
  logic              HoldE, FlushE;

  logic [DATA_W-1:0] RD1_outE, RD2_outE;
  logic [IMM_W-1:0]  extend_out;
  logic [RA_W-1:0]   RsE, RtE, RdE;
  logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [ALUC_W-1:0] ALUControlE;
  logic              ValidE;
  logic              StallD;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  RD1D, RD2D, ImmD, RsD, RtD, RdD,
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, ValidD,
    input  HoldE, FlushE,
    output RD1_outE, RD2_outE, extend_out, RsE, RtE, RdE,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE,
    output StallD, bubble_cnt
  );

  modport master (
    output RD1D, RD2D, ImmD, RsD, RtD, RdD,
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, ValidD,
    output HoldE, FlushE,
    input  RD1_outE, RD2_outE, extend_out, RsE, RtE, RdE,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE,
    input  StallD, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall, flush, hold and bubble counter
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  id_ex_pipe_reg_if.slave    bus
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [IMM_W-1:0]  imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic [ALUC_W-1:0] alu_ctrl;
    logic              valid;
  } stage_t;

  stage_t           e_q, e_d, d_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  always_comb begin
    d_in.rd1        = bus.RD1D;
    d_in.rd2        = bus.RD2D;
    d_in.imm        = bus.ImmD;
    d_in.rs         = bus.RsD;
    d_in.rt         = bus.RtD;
    d_in.rd         = bus.RdD;
    d_in.reg_write  = bus.RegWriteD;
    d_in.mem_to_reg = bus.MemtoRegD;
    d_in.mem_write  = bus.MemWriteD;
    d_in.alu_src    = bus.ALUSrcD;
    d_in.reg_dst    = bus.RegDstD;
    d_in.alu_ctrl   = bus.ALUControlD;
    d_in.valid      = bus.ValidD;
  end

  // A load in EX whose destination feeds either decode source must be separated by one bubble.
  assign lu = e_q.valid & e_q.mem_to_reg & (e_q.rt != '0) & bus.ValidD &
              ((e_q.rt == bus.RsD) | (e_q.rt == bus.RtD));

  assign bus.StallD = lu | bus.HoldE;

  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (!bus.HoldE) begin
      if (bus.FlushE || lu) begin
        e_d = '0;
        if (lu && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        e_d = d_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.RD1_outE    = e_q.rd1;
  assign bus.RD2_outE    = e_q.rd2;
  assign bus.extend_out  = e_q.imm;
  assign bus.RsE         = e_q.rs;
  assign bus.RtE         = e_q.rt;
  assign bus.RdE         = e_q.rd;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.RegDstE     = e_q.reg_dst;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.ValidE      = e_q.valid;
  assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed vector bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.CNT_W(2))  bus2 ();

  id_ex_pipe_reg #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_pipe_reg #(.CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  ctrl;   // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst}
    logic [2:0]  aluc;
    logic        vd, hold, flush;
    logic        x_stall;
    logic [31:0] x_rd2;
    logic [15:0] x_imm;
    logic        x_valid;
    logic [4:0]  x_rt;
    logic        x_mtr, x_rw;
    logic [15:0] x_cnt;
  } vec_t;

  function automatic vec_t mk(
      input logic [31:0] rd2, input logic [15:0] imm,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] ctrl, input logic [2:0] aluc,
      input logic vd, input logic hold, input logic flush, input logic x_stall,
      input logic [31:0] x_rd2, input logic [15:0] x_imm, input logic x_valid,
      input logic [4:0] x_rt, input logic x_mtr, input logic x_rw, input logic [15:0] x_cnt);
    vec_t v;
    v.rd2 = rd2; v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd;
    v.ctrl = ctrl; v.aluc = aluc; v.vd = vd; v.hold = hold; v.flush = flush;
    v.x_stall = x_stall; v.x_rd2 = x_rd2; v.x_imm = x_imm; v.x_valid = x_valid;
    v.x_rt = x_rt; v.x_mtr = x_mtr; v.x_rw = x_rw; v.x_cnt = x_cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.RD1D        = v.rd2 + 32'd1;
    bus.RD2D        = v.rd2;
    bus.ImmD        = v.imm;
    bus.RsD         = v.rs;
    bus.RtD         = v.rt;
    bus.RdD         = v.rd;
    bus.RegWriteD   = v.ctrl[4];
    bus.MemtoRegD   = v.ctrl[3];
    bus.MemWriteD   = v.ctrl[2];
    bus.ALUSrcD     = v.ctrl[1];
    bus.RegDstD     = v.ctrl[0];
    bus.ALUControlD = v.aluc;
    bus.ValidD      = v.vd;
    bus.HoldE       = v.hold;
    bus.FlushE      = v.flush;
  endtask

  vec_t vecs[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    bus2.RD1D = '0; bus2.RD2D = '0; bus2.ImmD = '0;
    bus2.RsD = '0; bus2.RtD = '0; bus2.RdD = '0;
    bus2.RegWriteD = 0; bus2.MemtoRegD = 0; bus2.MemWriteD = 0;
    bus2.ALUSrcD = 0; bus2.RegDstD = 0; bus2.ALUControlD = '0;
    bus2.ValidD = 0; bus2.HoldE = 0; bus2.FlushE = 0;

    //             rd2          imm      rs  rt  rd  ctrl      aluc vd h f  stall x_rd2        x_imm    xv xrt mtr rw cnt
    vecs.push_back(mk(32'h1234_5678, 16'hFFF0, 1, 2, 3, 5'b10011, 2, 1, 0, 0, 0, 32'h1234_5678, 16'hFFF0, 1, 2, 0, 1, 0));
    vecs.push_back(mk(32'h11, 16'h0004, 4, 8, 0, 5'b11010, 2, 1, 0, 0, 0, 32'h11, 16'h0004, 1, 8, 1, 1, 0));
    vecs.push_back(mk(32'h22, 16'h0000, 8, 9, 10, 5'b10001, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(32'h22, 16'h0000, 8, 9, 10, 5'b10001, 2, 1, 0, 0, 0, 32'h22, 16'h0000, 1, 9, 0, 1, 1));
    vecs.push_back(mk(32'h33, 16'h0008, 5, 0, 0, 5'b11010, 2, 1, 0, 0, 0, 32'h33, 16'h0008, 1, 0, 1, 1, 1));
    vecs.push_back(mk(32'h44, 16'h0010, 0, 0, 4, 5'b10001, 2, 1, 0, 0, 0, 32'h44, 16'h0010, 1, 0, 0, 1, 1));
    vecs.push_back(mk(32'h55, 16'h0020, 1, 6, 6, 5'b11111, 3, 1, 1, 1, 1, 32'h44, 16'h0010, 1, 0, 0, 1, 1));
    vecs.push_back(mk(32'h55, 16'h0020, 1, 6, 6, 5'b11111, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(32'h66, 16'h0001, 2, 7, 0, 5'b11000, 1, 0, 0, 0, 0, 32'h66, 16'h0001, 0, 7, 1, 1, 1));
    vecs.push_back(mk(32'h77, 16'h0002, 7, 1, 2, 5'b10000, 1, 1, 0, 0, 0, 32'h77, 16'h0002, 1, 1, 0, 1, 1));
    vecs.push_back(mk(32'h88, 16'h0003, 1, 12, 0, 5'b11010, 2, 1, 0, 0, 0, 32'h88, 16'h0003, 1, 12, 1, 1, 1));
    vecs.push_back(mk(32'h8a, 16'h0009, 3, 12, 4, 5'b10001, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(32'h99, 16'h0004, 2, 13, 0, 5'b11010, 2, 1, 0, 0, 0, 32'h99, 16'h0004, 1, 13, 1, 1, 2));
    vecs.push_back(mk(32'h9a, 16'h0006, 13, 3, 5, 5'b10001, 2, 1, 1, 0, 1, 32'h99, 16'h0004, 1, 13, 1, 1, 2));
    vecs.push_back(mk(32'h9a, 16'h0006, 13, 3, 5, 5'b10001, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(32'haa, 16'h0005, 13, 14, 5, 5'b10001, 2, 1, 0, 0, 0, 32'haa, 16'h0005, 1, 14, 0, 1, 3));

    // Reset held for two edges; everything must read zero.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.ValidE, 0);
    chk("rst_rd1", bus.RD1_outE, 0);
    chk("rst_rd2", bus.RD2_outE, 0);
    chk("rst_imm", bus.extend_out, 0);
    chk("rst_ctrl", {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE}, 0);
    chk("rst_addr", {bus.RsE, bus.RtE, bus.RdE, bus.ALUControlE}, 0);
    chk("rst_cnt", bus.bubble_cnt, 0);
    chk("rst_stall", bus.StallD, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), bus.StallD, vecs[i].x_stall);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rd2", i), bus.RD2_outE, vecs[i].x_rd2);
      chk($sformatf("v%0d_rd1", i), bus.RD1_outE, (vecs[i].x_rd2 == 0) ? 32'd0 : vecs[i].x_rd2 + 32'd1);
      chk($sformatf("v%0d_imm", i), bus.extend_out, vecs[i].x_imm);
      chk($sformatf("v%0d_valid", i), bus.ValidE, vecs[i].x_valid);
      chk($sformatf("v%0d_rt", i), bus.RtE, vecs[i].x_rt);
      chk($sformatf("v%0d_mtr", i), bus.MemtoRegE, vecs[i].x_mtr);
      chk($sformatf("v%0d_rw", i), bus.RegWriteE, vecs[i].x_rw);
      chk($sformatf("v%0d_mw", i), bus.MemWriteE, 0);
      chk($sformatf("v%0d_cnt", i), bus.bubble_cnt, vecs[i].x_cnt);
    end
    chk("alusrc_first", 32'(vecs[0].ctrl[1]), 1);

    // Asynchronous reset between edges while EX holds a valid instruction.
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ValidE, 0);
    chk("arst_rd2", bus.RD2_outE, 0);
    chk("arst_imm", bus.extend_out, 0);
    chk("arst_rw", bus.RegWriteE, 0);
    chk("arst_rt", bus.RtE, 0);
    chk("arst_cnt", bus.bubble_cnt, 0);
    chk("arst_stall", bus.StallD, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release loads normally, even with a would-be dependency.
    drive(mk(32'hbeef, 16'h8000, 14, 14, 1, 5'b11010, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post_rst_stall", bus.StallD, 0);
    @(posedge clk);
    #1;
    chk("post_rst_rd2", bus.RD2_outE, 32'hbeef);
    chk("post_rst_imm", bus.extend_out, 16'h8000);
    chk("post_rst_valid", bus.ValidE, 1);
    chk("post_rst_alusrc", bus.ALUSrcE, 1);

    // Saturation with a 2-bit counter: a self-dependent load alternates load/bubble.
    bus2.ValidD = 1; bus2.MemtoRegD = 1; bus2.RegWriteD = 1;
    bus2.RsD = 5'd8; bus2.RtD = 5'd8; bus2.RD2D = 32'h5a;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_load%0d_valid", k), bus2.ValidE, 1);
      chk($sformatf("sat_load%0d_stall", k), bus2.StallD, 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_bub%0d_valid", k), bus2.ValidE, 0);
      chk($sformatf("sat_bub%0d_cnt", k), bus2.bubble_cnt, (k < 3) ? k + 1 : 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
